// File: rtl/bootrom_arbiter_if.sv
// Instruction-fetch and data-load request/response bus between the bus adapters and the boot ROM arbiter.
interface bootrom_arbiter_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32
);
  logic                  i_req;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  i_grant;
  logic                  i_stall;
  logic                  i_rvalid;
  logic [DATA_WIDTH-1:0] i_rdata;
  logic [DATA_WIDTH-1:0] i_rdata_2;

  logic                  d_req;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic                  d_grant;
  logic                  d_stall;
  logic                  d_rvalid;
  logic [DATA_WIDTH-1:0] d_rdata;

  modport master (
    output i_req, i_addr, d_req, d_addr,
    input  i_grant, i_stall, i_rvalid, i_rdata, i_rdata_2,
    input  d_grant, d_stall, d_rvalid, d_rdata
  );

  modport slave (
    input  i_req, i_addr, d_req, d_addr,
    output i_grant, i_stall, i_rvalid, i_rdata, i_rdata_2,
    output d_grant, d_stall, d_rvalid, d_rdata
  );
endinterface

// File: rtl/bootrom_arbiter.sv
// Round-robin sharing of the dual-port boot ROM between instruction fetch (two words) and data load (one word).
module bootrom_arbiter #(
  parameter int ADDR_WIDTH  = 13,
  parameter int DATA_WIDTH  = 32,
  parameter int ROM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  bootrom_arbiter_if.slave      bus,
  output logic [ADDR_WIDTH-1:0] rom_addra,
  output logic [ADDR_WIDTH-1:0] rom_addrb,
  input  logic [DATA_WIDTH-1:0] rom_douta,
  input  logic [DATA_WIDTH-1:0] rom_doutb,
  input  logic                  cnt_clear,
  output logic [15:0]           conflict_cnt
);
  typedef enum logic {OWN_INST = 1'b0, OWN_DATA = 1'b1} owner_t;

  owner_t                  last_owner;
  owner_t                  grant_owner;
  logic                    grant_i;
  logic                    grant_d;
  logic                    grant_any;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [ADDR_WIDTH-1:0]   addr_a_q;
  logic [ADDR_WIDTH-1:0]   addr_b_q;
  logic [ROM_LATENCY-1:0]  pipe_valid;
  owner_t                  pipe_owner [ROM_LATENCY];
  logic                    out_valid;
  owner_t                  out_owner;

  // Grants are gated by reset so every handshake output drops the moment reset asserts.
  always_comb begin
    grant_i     = rst & bus.i_req & (~bus.d_req | (last_owner == OWN_DATA));
    grant_d     = rst & bus.d_req & (~bus.i_req | (last_owner == OWN_INST));
    grant_any   = grant_i | grant_d;
    grant_owner = grant_d ? OWN_DATA : OWN_INST;
    sel_addr    = grant_d ? bus.d_addr : bus.i_addr;
    rom_addra   = grant_any ? sel_addr : addr_a_q;
    rom_addrb   = grant_any ? sel_addr + ADDR_WIDTH'(1) : addr_b_q;
  end

  assign bus.i_grant = grant_i;
  assign bus.d_grant = grant_d;
  assign bus.i_stall = rst & bus.i_req & ~grant_i;
  assign bus.d_stall = rst & bus.d_req & ~grant_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_owner   <= OWN_DATA;
      addr_a_q     <= '0;
      addr_b_q     <= '0;
      pipe_valid   <= '0;
      for (int k = 0; k < ROM_LATENCY; k++) pipe_owner[k] <= OWN_INST;
      conflict_cnt <= '0;
    end else begin
      if (grant_any) begin
        last_owner <= grant_owner;
        addr_a_q   <= rom_addra;
        addr_b_q   <= rom_addrb;
      end
      pipe_valid[0] <= grant_any;
      pipe_owner[0] <= grant_owner;
      for (int k = 1; k < ROM_LATENCY; k++) begin
        pipe_valid[k] <= pipe_valid[k-1];
        pipe_owner[k] <= pipe_owner[k-1];
      end
      if (cnt_clear)
        conflict_cnt <= '0;
      else if (bus.i_req & bus.d_req & (conflict_cnt != 16'hFFFF))
        conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

  // The last pipeline stage lines up with the ROM data for the access it tracks.
  assign out_valid     = pipe_valid[ROM_LATENCY-1];
  assign out_owner     = pipe_owner[ROM_LATENCY-1];
  assign bus.i_rvalid  = out_valid & (out_owner == OWN_INST);
  assign bus.d_rvalid  = out_valid & (out_owner == OWN_DATA);
  assign bus.i_rdata   = bus.i_rvalid ? rom_douta : '0;
  assign bus.i_rdata_2 = bus.i_rvalid ? rom_doutb : '0;
  assign bus.d_rdata   = bus.d_rvalid ? rom_douta : '0;
endmodule

// File: tb/tb_bootrom_arbiter.sv
// Directed self-checking bench for bootrom_arbiter at ROM_LATENCY 1 and 3.
module tb_bootrom_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic cnt_clear1, cnt_clear3;
  logic [12:0] r1_addra, r1_addrb, r3_addra, r3_addrb;
  logic [31:0] r1_douta, r1_doutb, r3_douta, r3_doutb;
  logic [15:0] cnt1, cnt3;
  logic [31:0] p3a [3];
  logic [31:0] p3b [3];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bootrom_arbiter_if #(.ADDR_WIDTH(13), .DATA_WIDTH(32)) bus1 ();
  bootrom_arbiter_if #(.ADDR_WIDTH(13), .DATA_WIDTH(32)) bus3 ();

  bootrom_arbiter #(.ADDR_WIDTH(13), .DATA_WIDTH(32), .ROM_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave),
    .rom_addra(r1_addra), .rom_addrb(r1_addrb), .rom_douta(r1_douta), .rom_doutb(r1_doutb),
    .cnt_clear(cnt_clear1), .conflict_cnt(cnt1));

  bootrom_arbiter #(.ADDR_WIDTH(13), .DATA_WIDTH(32), .ROM_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3.slave),
    .rom_addra(r3_addra), .rom_addrb(r3_addrb), .rom_douta(r3_douta), .rom_doutb(r3_doutb),
    .cnt_clear(cnt_clear3), .conflict_cnt(cnt3));

  function automatic logic [31:0] rom_fn(input logic [12:0] a);
    return {8'hA5, 3'b000, a, 8'h5A};
  endfunction

  // ROM macro models
  always @(posedge clk) begin
    r1_douta <= rom_fn(r1_addra);
    r1_doutb <= rom_fn(r1_addrb);
    p3a[0] <= rom_fn(r3_addra);
    p3b[0] <= rom_fn(r3_addrb);
    p3a[1] <= p3a[0];
    p3b[1] <= p3b[0];
    p3a[2] <= p3a[1];
    p3b[2] <= p3b[1];
  end
  assign r3_douta = p3a[2];
  assign r3_doutb = p3b[2];

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus1.i_req = 1'b1; bus1.i_addr = 13'h0AA;
    bus1.d_req = 1'b1; bus1.d_addr = 13'h0BB;
    @(negedge clk);
    checks++;
    if (bus1.i_grant !== 1'b0 || bus1.d_grant !== 1'b0 || bus1.i_stall !== 1'b0 || bus1.d_stall !== 1'b0) begin
      errors++; $display("FAIL reset_grant_stall: got %b%b%b%b expected 0000", bus1.i_grant, bus1.d_grant, bus1.i_stall, bus1.d_stall);
    end
    checks++;
    if (bus1.i_rvalid !== 1'b0 || bus1.d_rvalid !== 1'b0 || bus1.i_rdata !== 32'h0 || bus1.d_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_resp: got %b %b %h %h expected 0 0 0 0", bus1.i_rvalid, bus1.d_rvalid, bus1.i_rdata, bus1.d_rdata);
    end
    checks++;
    if (r1_addra !== 13'h0 || r1_addrb !== 13'h0 || cnt1 !== 16'h0) begin
      errors++; $display("FAIL reset_addr_cnt: got %h %h %h expected 0 0 0", r1_addra, r1_addrb, cnt1);
    end
    bus1.i_req = 1'b0; bus1.d_req = 1'b0;
    next_cycle();
  endtask

  task automatic test_single_fetch();
    rst = 1'b1;
    bus1.i_req = 1'b1; bus1.i_addr = 13'h010;
    @(negedge clk);
    checks++;
    if (bus1.i_grant !== 1'b1 || r1_addra !== 13'h010 || r1_addrb !== 13'h011) begin
      errors++; $display("FAIL single_grant: got %b %h %h expected 1 010 011", bus1.i_grant, r1_addra, r1_addrb);
    end
    next_cycle();
    bus1.i_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus1.i_rvalid !== 1'b1 || bus1.i_rdata !== rom_fn(13'h010) || bus1.i_rdata_2 !== rom_fn(13'h011) || bus1.d_rvalid !== 1'b0) begin
      errors++; $display("FAIL single_resp: got %b %h %h %b expected 1 %h %h 0", bus1.i_rvalid, bus1.i_rdata, bus1.i_rdata_2, bus1.d_rvalid, rom_fn(13'h010), rom_fn(13'h011));
    end
    next_cycle();
  endtask

  task automatic test_conflict();
    logic exp_ig, exp_dg, exp_iv, exp_dv;
    logic [12:0] exp_a;
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      bus1.i_req = (c < 4); bus1.i_addr = 13'h020;
      bus1.d_req = (c < 4); bus1.d_addr = 13'h100;
      exp_ig = (c < 4) && (c % 2 == 0);
      exp_dg = (c < 4) && (c % 2 == 1);
      exp_iv = (c == 1) || (c == 3);
      exp_dv = (c == 2) || (c == 4);
      exp_a  = exp_dg ? 13'h100 : 13'h020;
      @(negedge clk);
      checks++;
      if (bus1.i_grant !== exp_ig || bus1.d_grant !== exp_dg || bus1.i_stall !== exp_dg || bus1.d_stall !== exp_ig) begin
        errors++; $display("FAIL conflict_grant c%0d: got ig%b dg%b is%b ds%b expected ig%b dg%b is%b ds%b", c,
          bus1.i_grant, bus1.d_grant, bus1.i_stall, bus1.d_stall, exp_ig, exp_dg, exp_dg, exp_ig);
      end
      if (c < 4) begin
        checks++;
        if (r1_addra !== exp_a) begin
          errors++; $display("FAIL conflict_addr c%0d: got %h expected %h", c, r1_addra, exp_a);
        end
      end
      checks++;
      if (bus1.i_rvalid !== exp_iv || bus1.d_rvalid !== exp_dv) begin
        errors++; $display("FAIL conflict_rvalid c%0d: got i%b d%b expected i%b d%b", c, bus1.i_rvalid, bus1.d_rvalid, exp_iv, exp_dv);
      end
      if (exp_iv) begin
        checks++;
        if (bus1.i_rdata !== rom_fn(13'h020) || bus1.i_rdata_2 !== rom_fn(13'h021)) begin
          errors++; $display("FAIL conflict_idata c%0d: got %h %h expected %h %h", c, bus1.i_rdata, bus1.i_rdata_2, rom_fn(13'h020), rom_fn(13'h021));
        end
      end
      if (exp_dv) begin
        checks++;
        if (bus1.d_rdata !== rom_fn(13'h100)) begin
          errors++; $display("FAIL conflict_ddata c%0d: got %h expected %h", c, bus1.d_rdata, rom_fn(13'h100));
        end
      end
      if (c == 4) begin
        checks++;
        if (cnt1 !== 16'd4) begin
          errors++; $display("FAIL conflict_cnt: got %0d expected 4", cnt1);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_wrap();
    bus1.i_req = 1'b1; bus1.i_addr = 13'h1FFF;
    @(negedge clk);
    checks++;
    if (bus1.i_grant !== 1'b1 || r1_addra !== 13'h1FFF || r1_addrb !== 13'h0000) begin
      errors++; $display("FAIL wrap_addr: got %b %h %h expected 1 1fff 0000", bus1.i_grant, r1_addra, r1_addrb);
    end
    next_cycle();
    bus1.i_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus1.i_rvalid !== 1'b1 || bus1.i_rdata !== rom_fn(13'h1FFF) || bus1.i_rdata_2 !== rom_fn(13'h0000)) begin
      errors++; $display("FAIL wrap_data: got %b %h %h expected 1 %h %h", bus1.i_rvalid, bus1.i_rdata, bus1.i_rdata_2, rom_fn(13'h1FFF), rom_fn(13'h0000));
    end
    next_cycle();
  endtask

  task automatic test_reset_midflight();
    bus1.d_req = 1'b1; bus1.d_addr = 13'h055;
    @(negedge clk);
    checks++;
    if (bus1.d_grant !== 1'b1) begin
      errors++; $display("FAIL midflight_grant: got %b expected 1", bus1.d_grant);
    end
    next_cycle();
    rst = 1'b0;
    bus1.i_req = 1'b1; bus1.i_addr = 13'h077;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (bus1.i_grant !== 1'b0 || bus1.d_grant !== 1'b0 || bus1.i_stall !== 1'b0 || bus1.d_stall !== 1'b0 ||
          bus1.i_rvalid !== 1'b0 || bus1.d_rvalid !== 1'b0 || bus1.i_rdata !== 32'h0 || bus1.i_rdata_2 !== 32'h0 ||
          bus1.d_rdata !== 32'h0 || r1_addra !== 13'h0 || r1_addrb !== 13'h0 || cnt1 !== 16'h0) begin
        errors++; $display("FAIL midflight_zero c%0d: got g%b%b s%b%b v%b%b d%h a%h/%h n%h expected all zero", c,
          bus1.i_grant, bus1.d_grant, bus1.i_stall, bus1.d_stall, bus1.i_rvalid, bus1.d_rvalid, bus1.d_rdata, r1_addra, r1_addrb, cnt1);
      end
      next_cycle();
    end
    rst = 1'b1;
    bus1.i_req = 1'b0; bus1.d_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus1.d_rvalid !== 1'b0 || bus1.i_rvalid !== 1'b0) begin
      errors++; $display("FAIL midflight_drop: got d%b i%b expected 0 0", bus1.d_rvalid, bus1.i_rvalid);
    end
    next_cycle();
    bus1.i_req = 1'b1; bus1.i_addr = 13'h030;
    bus1.d_req = 1'b1; bus1.d_addr = 13'h040;
    @(negedge clk);
    checks++;
    if (bus1.i_grant !== 1'b1 || bus1.d_grant !== 1'b0 || bus1.d_rvalid !== 1'b0) begin
      errors++; $display("FAIL midflight_prio: got ig%b dg%b dv%b expected 1 0 0", bus1.i_grant, bus1.d_grant, bus1.d_rvalid);
    end
    next_cycle();
    bus1.i_req = 1'b0; bus1.d_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus1.i_rvalid !== 1'b1 || bus1.i_rdata !== rom_fn(13'h030) || bus1.d_rvalid !== 1'b0) begin
      errors++; $display("FAIL midflight_resp: got %b %h %b expected 1 %h 0", bus1.i_rvalid, bus1.i_rdata, bus1.d_rvalid, rom_fn(13'h030));
    end
    next_cycle();
  endtask

  task automatic test_saturate();
    cnt_clear1 = 1'b1;
    next_cycle();
    cnt_clear1 = 1'b0;
    bus1.i_req = 1'b1; bus1.i_addr = 13'h001;
    bus1.d_req = 1'b1; bus1.d_addr = 13'h002;
    repeat (65534) @(posedge clk);
    @(negedge clk);
    checks++;
    if (cnt1 !== 16'hFFFE) begin
      errors++; $display("FAIL sat_fffe: got %h expected fffe", cnt1);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (cnt1 !== 16'hFFFF) begin
      errors++; $display("FAIL sat_ffff: got %h expected ffff", cnt1);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (cnt1 !== 16'hFFFF) begin
      errors++; $display("FAIL sat_stick: got %h expected ffff", cnt1);
    end
    next_cycle();
    cnt_clear1 = 1'b1;
    next_cycle();
    @(negedge clk);
    checks++;
    if (cnt1 !== 16'h0) begin
      errors++; $display("FAIL sat_clear: got %h expected 0000", cnt1);
    end
    cnt_clear1 = 1'b0;
    bus1.i_req = 1'b0; bus1.d_req = 1'b0;
    next_cycle();
  endtask

  task automatic test_back_to_back_lat3();
    logic        exp_own [10];
    logic [12:0] exp_adr [10];
    logic [12:0] ia, da;
    int          ngrant;
    int          nresp;
    logic        own;
    ia = 13'h200; da = 13'h1F0; ngrant = 0; nresp = 0;
    for (int t = 0; t < 14; t++) begin
      bus3.i_req = (t < 10); bus3.i_addr = ia;
      bus3.d_req = (t < 10); bus3.d_addr = da;
      @(negedge clk);
      if (t < 10) begin
        checks++;
        if (bus3.i_grant !== (t % 2 == 0) || bus3.d_grant !== (t % 2 == 1)) begin
          errors++; $display("FAIL lat3_grant t%0d: got i%b d%b expected i%b d%b", t, bus3.i_grant, bus3.d_grant, (t % 2 == 0), (t % 2 == 1));
        end
        exp_own[t] = (t % 2 == 1);
        exp_adr[t] = (t % 2 == 1) ? da : ia;
        ngrant++;
      end
      if (t >= 3 && t - 3 < 10) begin
        own = exp_own[t-3];
        checks++;
        if (bus3.i_rvalid !== !own || bus3.d_rvalid !== own) begin
          errors++; $display("FAIL lat3_rvalid t%0d: got i%b d%b expected i%b d%b", t, bus3.i_rvalid, bus3.d_rvalid, !own, own);
        end else begin
          nresp++;
        end
        checks++;
        if (!own && (bus3.i_rdata !== rom_fn(exp_adr[t-3]) || bus3.i_rdata_2 !== rom_fn(exp_adr[t-3] + 13'd1))) begin
          errors++; $display("FAIL lat3_idata t%0d: got %h %h expected %h %h", t, bus3.i_rdata, bus3.i_rdata_2, rom_fn(exp_adr[t-3]), rom_fn(exp_adr[t-3] + 13'd1));
        end else if (own && bus3.d_rdata !== rom_fn(exp_adr[t-3])) begin
          errors++; $display("FAIL lat3_ddata t%0d: got %h expected %h", t, bus3.d_rdata, rom_fn(exp_adr[t-3]));
        end
      end else begin
        checks++;
        if (bus3.i_rvalid !== 1'b0 || bus3.d_rvalid !== 1'b0) begin
          errors++; $display("FAIL lat3_idle t%0d: got i%b d%b expected 0 0", t, bus3.i_rvalid, bus3.d_rvalid);
        end
      end
      if (t < 10) begin
        if (t % 2 == 0) ia = ia + 13'd1;
        else            da = da + 13'd8;
      end
      next_cycle();
    end
    checks++;
    if (nresp != 10 || ngrant != 10) begin
      errors++; $display("FAIL lat3_count: got %0d responses %0d grants expected 10 10", nresp, ngrant);
    end
    bus3.i_req = 1'b0; bus3.d_req = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    cnt_clear1 = 1'b0; cnt_clear3 = 1'b0;
    bus1.i_req = 1'b0; bus1.i_addr = '0; bus1.d_req = 1'b0; bus1.d_addr = '0;
    bus3.i_req = 1'b0; bus3.i_addr = '0; bus3.d_req = 1'b0; bus3.d_addr = '0;
    next_cycle();
    test_reset();
    test_single_fetch();
    test_conflict();
    test_wrap();
    test_reset_midflight();
    test_saturate();
    test_back_to_back_lat3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
